// File: rtl/bus_transfer_sequencer.sv
// Bus transfer sequencer: round-robin arbitration of four requesters for a
// shared register bus, sequencing tristate selects and load enables for a
// source-to-destination register copy.
module bus_transfer_sequencer #(
  parameter int unsigned DriveCycles = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        tick_i,
  input  logic [3:0]  req_i,
  input  logic [11:0] src_i,
  input  logic [11:0] dst_i,
  output logic [3:0]  grant_o,
  output logic [3:0]  done_o,
  output logic [7:0]  cs_o,
  output logic [7:0]  ld_o,
  output logic        busy_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_LATCH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Last value of the drive counter before moving on to the load phase.
  localparam logic [1:0] DriveLast = 2'(DriveCycles - 1);

  state_e      state_q;
  logic [1:0]  ptr_q;
  logic [1:0]  cnt_q;
  logic [2:0]  src_q;
  logic [2:0]  dst_q;
  logic [3:0]  grant_q;
  logic [3:0]  done_q;
  logic [7:0]  cs_q;
  logic [7:0]  ld_q;
  logic        busy_q;
  logic        err_q;

  logic        win_valid_d;
  logic [1:0]  win_idx_d;
  logic [1:0]  cand_d;
  logic [2:0]  win_src_d;
  logic [2:0]  win_dst_d;

  // Round-robin search starting at the pointer, ascending modulo 4.
  always_comb begin
    win_valid_d = 1'b0;
    win_idx_d   = 2'd0;
    cand_d      = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand_d = ptr_q + 2'(k);
      if (!win_valid_d && req_i[cand_d]) begin
        win_valid_d = 1'b1;
        win_idx_d   = cand_d;
      end
    end
  end

  // Select the winning requester's source and destination indices.
  always_comb begin
    win_src_d = src_i[2:0];
    win_dst_d = dst_i[2:0];
    case (win_idx_d)
      2'd1: begin
        win_src_d = src_i[5:3];
        win_dst_d = dst_i[5:3];
      end
      2'd2: begin
        win_src_d = src_i[8:6];
        win_dst_d = dst_i[8:6];
      end
      2'd3: begin
        win_src_d = src_i[11:9];
        win_dst_d = dst_i[11:9];
      end
      default: begin
        win_src_d = src_i[2:0];
        win_dst_d = dst_i[2:0];
      end
    endcase
  end

  // Transfer FSM with registered bus controls; done/err self-clear each cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      ptr_q   <= 2'd0;
      cnt_q   <= 2'd0;
      src_q   <= 3'd0;
      dst_q   <= 3'd0;
      grant_q <= 4'd0;
      done_q  <= 4'd0;
      cs_q    <= 8'hFF;
      ld_q    <= 8'h00;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 4'd0;
      err_q  <= 1'b0;
      if (tick_i) begin
        case (state_q)
          ST_IDLE: begin
            if (win_valid_d) begin
              grant_q <= 4'b0001 << win_idx_d;
              src_q   <= win_src_d;
              dst_q   <= win_dst_d;
              ptr_q   <= win_idx_d + 2'd1;
              busy_q  <= 1'b1;
              cnt_q   <= 2'd0;
              if (win_src_d == win_dst_d) begin
                // Self-copy needs no bus activity: report completion with error.
                state_q <= ST_DONE;
                done_q  <= 4'b0001 << win_idx_d;
                err_q   <= 1'b1;
              end else begin
                state_q <= ST_DRIVE;
                cs_q    <= ~(8'b0000_0001 << win_src_d);
              end
            end
          end
          ST_DRIVE: begin
            if (cnt_q == DriveLast) begin
              state_q <= ST_LATCH;
              ld_q    <= 8'b0000_0001 << dst_q;
            end else begin
              cnt_q <= cnt_q + 2'd1;
            end
          end
          ST_LATCH: begin
            state_q <= ST_DONE;
            cs_q    <= 8'hFF;
            ld_q    <= 8'h00;
            done_q  <= grant_q;
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
            grant_q <= 4'd0;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            grant_q <= 4'd0;
            cs_q    <= 8'hFF;
            ld_q    <= 8'h00;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign grant_o = grant_q;
  assign done_o  = done_q;
  assign cs_o    = cs_q;
  assign ld_o    = ld_q;
  assign busy_o  = busy_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Testbench for bus_transfer_sequencer: two instances (DriveCycles 1 and 4)
// run in lockstep against a transfer-level reference model.
module tb_bus_transfer_sequencer;

  logic        clk;
  logic        rst_n;
  logic        tick;
  logic [3:0]  req;
  logic [11:0] src;
  logic [11:0] dst;

  logic [3:0]  grant0, done0, grant1, done1;
  logic [7:0]  cs0, ld0, cs1, ld1;
  logic        busy0, err0, busy1, err1;

  int n_cmp;
  int n_fail;

  // Reference model state per instance: an active transfer is a sequence of
  // Tick periods: DriveCycles drive periods, one load period, one done period
  // (only the done period for a self-copy).
  int m_dc   [2];
  int m_act  [2];
  int m_pos  [2];
  int m_len  [2];
  int m_own  [2];
  int m_s    [2];
  int m_d    [2];
  int m_p    [2];
  int m_fresh[2];

  int order [5];
  int n_order;

  bus_transfer_sequencer #(.DriveCycles(1)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .req_i(req), .src_i(src), .dst_i(dst),
    .grant_o(grant0), .done_o(done0), .cs_o(cs0), .ld_o(ld0), .busy_o(busy0), .err_o(err0)
  );

  bus_transfer_sequencer #(.DriveCycles(4)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .req_i(req), .src_i(src), .dst_i(dst),
    .grant_o(grant1), .done_o(done1), .cs_o(cs1), .ld_o(ld1), .busy_o(busy1), .err_o(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      m_act[n] = 0; m_pos[n] = 0; m_len[n] = 0; m_own[n] = 0;
      m_s[n] = 0; m_d[n] = 0; m_p[n] = 0; m_fresh[n] = 0;
    end
  endtask

  // Advance the model of instance n by one clock edge using current inputs.
  task automatic model_edge(input int n);
    int c;
    m_fresh[n] = 0;
    if (tick) begin
      if (m_act[n] != 0) begin
        m_pos[n] = m_pos[n] + 1;
        if (m_pos[n] >= m_len[n]) m_act[n] = 0;
        else if (m_pos[n] == m_len[n] - 1) m_fresh[n] = 1;
      end else begin
        for (int i = 0; i < 4; i++) begin
          c = (m_p[n] + i) % 4;
          if (m_act[n] == 0 && req[c]) begin
            m_act[n] = 1;
            m_own[n] = c;
            m_s[n]   = (src >> (3 * c)) & 7;
            m_d[n]   = (dst >> (3 * c)) & 7;
            m_p[n]   = (c + 1) % 4;
            m_pos[n] = 0;
            m_len[n] = (m_s[n] == m_d[n]) ? 1 : m_dc[n] + 2;
            if (m_len[n] == 1) m_fresh[n] = 1;
          end
        end
      end
    end
  endtask

  task automatic check_inst(input int n);
    logic [3:0] eg, ed, ag, ad;
    logic [7:0] ec, el, ac, al;
    logic       eb, ee, ab, ae;
    string      pfx;
    pfx = (n == 0) ? "dc1" : "dc4";
    ag = (n == 0) ? grant0 : grant1;
    ad = (n == 0) ? done0  : done1;
    ac = (n == 0) ? cs0    : cs1;
    al = (n == 0) ? ld0    : ld1;
    ab = (n == 0) ? busy0  : busy1;
    ae = (n == 0) ? err0   : err1;
    eg = 4'h0; ed = 4'h0; ec = 8'hFF; el = 8'h00; eb = 1'b0; ee = 1'b0;
    if (m_act[n] != 0) begin
      eg = 4'(1 << m_own[n]);
      eb = 1'b1;
      if (m_len[n] > 1 && m_pos[n] <= m_dc[n]) ec = ~8'(1 << m_s[n]);
      if (m_len[n] > 1 && m_pos[n] == m_dc[n]) el = 8'(1 << m_d[n]);
      if (m_fresh[n] != 0) begin
        ed = eg;
        ee = (m_s[n] == m_d[n]);
      end
    end
    chk({pfx, ".grant"}, 32'(ag), 32'(eg));
    chk({pfx, ".done"},  32'(ad), 32'(ed));
    chk({pfx, ".cs"},    32'(ac), 32'(ec));
    chk({pfx, ".ld"},    32'(al), 32'(el));
    chk({pfx, ".busy"},  32'(ab), 32'(eb));
    chk({pfx, ".err"},   32'(ae), 32'(ee));
  endtask

  // One clock: drive inputs, update the model at the edge, check at negedge.
  task automatic step(input logic t, input logic [3:0] r, input logic [11:0] s, input logic [11:0] d);
    tick = t; req = r; src = s; dst = d;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    check_inst(0);
    check_inst(1);
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear immediately.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_inst(0);
    check_inst(1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [3:0] prev_g;

  initial begin
    n_cmp = 0; n_fail = 0; n_order = 0;
    m_dc[0] = 1; m_dc[1] = 4;
    tick = 1'b0; req = 4'h0; src = 12'h0; dst = 12'h0;
    rst_n = 1'b1;
    @(negedge clk);
    do_reset();

    // Single transfer: requester 0 copies r2 -> r5.
    step(1'b1, 4'b0001, 12'o0002, 12'o0005);
    chk("single.grant", 32'(grant0), 32'h1);
    chk("single.cs_drive", 32'(cs0), 32'hFB);
    step(1'b1, 4'b0000, 12'o0002, 12'o0005);
    chk("single.cs_latch", 32'(cs0), 32'hFB);
    chk("single.ld_latch", 32'(ld0), 32'h20);
    step(1'b1, 4'b0000, 12'o0000, 12'o0000);
    chk("single.done", 32'(done0), 32'h1);
    step(1'b1, 4'b0000, 12'o0000, 12'o0000);
    chk("single.busy_idle", 32'(busy0), 32'h0);
    for (int i = 0; i < 8; i++) step(1'b1, 4'b0000, 12'o0000, 12'o0000);

    // Contention: all four held, grant order recorded from instance 0.
    do_reset();
    prev_g = 4'h0;
    for (int i = 0; i < 24; i++) begin
      step(1'b1, 4'b1111, 12'o3210, 12'o4567);
      if (grant0 != 4'h0 && prev_g == 4'h0 && n_order < 5) begin
        for (int k = 0; k < 4; k++) if (grant0[k]) order[n_order] = k;
        n_order++;
      end
      prev_g = grant0;
    end
    for (int k = 0; k < 5; k++) begin
      if (k >= n_order) order[k] = -1;
      chk("rr.order", 32'(order[k]), 32'(k % 4));
    end
    for (int i = 0; i < 30; i++) step(1'b1, 4'b0000, 12'o0000, 12'o0000);

    // Tick gating: Tick every third cycle, single request.
    for (int i = 0; i < 45; i++)
      step((i % 3) == 2, (i < 6) ? 4'b0010 : 4'b0000, 12'o0060, 12'o0010);
    for (int i = 0; i < 12; i++) step(1'b1, 4'b0000, 12'o0000, 12'o0000);

    // Self-copy on requester 2, then a full request set shows the pointer at 3.
    step(1'b1, 4'b0100, 12'o0300, 12'o0300);
    step(1'b1, 4'b0000, 12'o0300, 12'o0300);
    step(1'b1, 4'b0000, 12'o0000, 12'o0000);
    step(1'b1, 4'b1111, 12'o1234, 12'o5670);
    chk("selfcopy.next_grant", 32'(grant0), 32'h8);
    for (int i = 0; i < 12; i++) step(1'b1, 4'b0000, 12'o0000, 12'o0000);

    // Abort during the load phase of instance 0.
    step(1'b1, 4'b0001, 12'o0001, 12'o0007);
    step(1'b1, 4'b0000, 12'o0001, 12'o0007);
    chk("abort.in_latch", 32'(ld0), 32'h80);
    do_reset();
    step(1'b1, 4'b0010, 12'o0040, 12'o0030);
    chk("abort.regrant", 32'(grant0), 32'h2);
    for (int i = 0; i < 10; i++) step(1'b1, 4'b0000, 12'o0000, 12'o0000);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else step($urandom_range(0, 9) < 7,
                ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom),
                12'($urandom), 12'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_transfer_sequencer.md
BUS_TRANSFER_SEQUENCER -- requirements
Module: bus_transfer_sequencer

Interface
REQ-001 Parameter: DriveCycles, default 1, number of Tick-qualified cycles the source drives the bus before the load (legal range 1..4).
REQ-002 Clock  in  1  system clock; all state changes on rising edge.
REQ-003 Reset  in  1  asynchronous, active-low reset.
REQ-004 Tick  in  1  advance qualifier; the FSM changes state only on edges where Tick=1.
REQ-005 req  in  4  transfer request per requester i; level-sensitive.
REQ-006 src  in  12  source register index, requester i at bits [3i+2:3i].
REQ-007 dst  in  12  destination register index, requester i at bits [3i+2:3i].
REQ-008 grant  out  4  one-hot owner of the current transfer; all-zero when idle.
REQ-009 done  out  4  one-hot, one-cycle completion pulse to the owning requester.
REQ-010 cs  out  8  per-register tristate select; 1 = register output high-Z, 0 = register drives bus.
REQ-011 ld  out  8  per-register ClockEnable for bus load.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 err  out  1  one-cycle pulse with done when the granted request has src==dst.

Function
REQ-014 States: IDLE, DRIVE, LATCH, DONE; all transitions require Tick=1 on the edge.
REQ-015 IDLE: if any req bit is high, select the winner round-robin, register its grant, src, dst, go to DRIVE; else stay.
REQ-016 Round-robin: search starts at pointer p (reset value 0), ascending modulo 4; after a grant to i, p = (i+1) mod 4.
REQ-017 src/dst captured at grant; later changes to src, dst or req do not affect the transfer in flight.
REQ-018 DRIVE: cs[src_cap]=0, all other cs=1, ld=0; stays for DriveCycles Tick-qualified edges, then LATCH.
REQ-019 LATCH: cs[src_cap]=0 held, ld[dst_cap]=1, all other ld=0; one Tick-qualified edge, then DONE.
REQ-020 DONE: cs all ones, ld all zero, done[owner]=1 for exactly one Clock cycle (first cycle in DONE), then IDLE on next Tick edge.
REQ-021 grant[owner] stays high from entry to DRIVE through the DONE state; cleared on return to IDLE.
REQ-022 src_cap==dst_cap: DRIVE and LATCH skipped, cs all ones, ld all zero, go DONE directly, err=1 with done.
REQ-023 At most one cs bit is 0 at any time; at most one ld bit is 1 at any time; ld never high while cs all ones.
REQ-024 Requester dropping req after grant: transfer still completes and done still pulses.
REQ-025 Same requester holding req continuously: re-granted only after all other pending requesters served once.
REQ-026 Tick=0: state, counters, outputs held unchanged, except done/err which clear after their single cycle.
REQ-027 Drive counter width 2 bits; counts 0..DriveCycles-1, cleared on DRIVE entry.

Reset
REQ-028 Reset low forces immediately: state IDLE, p=0, grant=0, done=0, err=0, busy=0, ld=0, cs=8'hFF.
REQ-029 Reset asserted mid-transfer aborts it with no done pulse; no ld pulse is generated after reset release until a new grant.
REQ-030 First Tick-qualified edge after Reset high may grant.

Verification
REQ-031 Single: Tick=1, req=0001, src0=2, dst0=5, DriveCycles=1 -> grant=0001; cs=8'hFB for 2 cycles; ld=8'h20 in second; done=0001 next; back to IDLE, busy=0.
REQ-032 Contention: req=1111 held, all src!=dst -> grants in order 0001,0010,0100,1000,0001; each done pulses once.
REQ-033 Tick gating: Tick high every 3rd cycle, single request -> each state lasts 3 cycles, ld[dst] held through LATCH, done still 1 cycle.
REQ-034 Self-copy: req=0100, src2=dst2=3 -> cs stays 8'hFF, ld=0, done=0100 with err=1, p becomes 3.
REQ-035 Abort: Reset low during LATCH -> same cycle cs=8'hFF, ld=0, grant=0; no done; after release req=0010 granted first.
REQ-036 DriveCycles=4: single request -> DRIVE lasts 4 Tick edges, cs[src] low 5 Tick periods total before DONE.
